// File: rtl/mem_access_stage.sv
// Memory stage: EX/MEM register, req/ack data-memory access with byte-lane filtering, MEM/WB register.
// Stalls upstream while an aligned access is outstanding; misaligned accesses retire as bubbles.
module mem_access_stage #(
  parameter int unsigned PROC_BITS      = 32,
  parameter int unsigned PC_BITS        = 32,
  parameter int unsigned REG_ADDRS_BITS = 5,
  parameter int unsigned DMEM_ADDR_BITS = 10
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic [PROC_BITS-1:0]      i_alu_result,
  input  logic [PROC_BITS-1:0]      i_rt_data,
  input  logic [REG_ADDRS_BITS-1:0] i_rd,
  input  logic                      i_pc_to_reg,
  input  logic [PC_BITS-1:0]        i_pc_return,
  input  logic                      i_RegWrite,
  input  logic                      i_MemRead,
  input  logic                      i_MemWrite,
  input  logic                      i_MemtoReg,
  input  logic [2:0]                i_ls_filter_op,
  output logic                      o_dmem_req,
  output logic                      o_dmem_we,
  output logic [DMEM_ADDR_BITS-1:0] o_dmem_addr,
  output logic [31:0]               o_dmem_wdata,
  output logic [3:0]                o_dmem_wstrb,
  input  logic                      i_dmem_ack,
  input  logic [31:0]               i_dmem_rdata,
  output logic                      o_stall,
  output logic                      o_misaligned,
  output logic [PROC_BITS-1:0]      o_ex_mem_data,
  output logic [REG_ADDRS_BITS-1:0] o_ex_mem_rd,
  output logic                      o_ex_mem_RegWrite,
  output logic [PROC_BITS-1:0]      o_mem_wb_data,
  output logic [REG_ADDRS_BITS-1:0] o_mem_wb_rd,
  output logic                      o_mem_wb_RegWrite
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e state, state_next;

  logic [PROC_BITS-1:0]      em_alu, em_rt;
  logic [REG_ADDRS_BITS-1:0] em_rd;
  logic                      em_pc_to_reg;
  logic [PC_BITS-1:0]        em_pc_return;
  logic                      em_reg_write, em_mem_read, em_mem_write, em_mem_to_reg;
  logic [2:0]                em_ls_op;

  logic                      acc_done;
  logic                      mis_seen;
  logic [31:0]               cap_rdata;

  logic [PROC_BITS-1:0]      wb_data;
  logic [REG_ADDRS_BITS-1:0] wb_rd;
  logic                      wb_reg_write;

  logic                      is_byte, is_half, mem_op, misaligned, mis_op, access, advance;
  logic [1:0]                lane;
  logic [31:0]               store_data, rdata, load_val;
  logic [3:0]                store_strb;
  logic [7:0]                load_byte;
  logic [15:0]               load_half;
  logic [PROC_BITS-1:0]      ex_data;

  assign lane       = em_alu[1:0];
  assign is_byte    = (em_ls_op == 3'b000) || (em_ls_op == 3'b100);
  assign is_half    = (em_ls_op == 3'b001) || (em_ls_op == 3'b101);
  assign mem_op     = em_mem_read || em_mem_write;
  assign misaligned = is_half ? lane[0] : (!is_byte && (lane != 2'b00));
  assign mis_op     = mem_op && misaligned;
  // acc_done: the access completed while the pipeline was frozen; never re-issue it.
  assign access     = mem_op && !misaligned && !acc_done;
  assign advance    = i_enable && !o_stall;
  assign ex_data    = em_pc_to_reg ? PROC_BITS'(em_pc_return) : em_alu;

  always_comb begin
    store_data = em_rt[31:0];
    store_strb = 4'b1111;
    if (is_byte) begin
      store_data = {4{em_rt[7:0]}};
      store_strb = 4'b0001 << lane;
    end else if (is_half) begin
      store_data = {2{em_rt[15:0]}};
      store_strb = 4'b0011 << {lane[1], 1'b0};
    end
  end

  assign rdata     = acc_done ? cap_rdata : i_dmem_rdata;
  assign load_byte = rdata[{lane, 3'b000} +: 8];
  assign load_half = rdata[{lane[1], 4'b0000} +: 16];

  always_comb begin
    case (em_ls_op)
      3'b000:  load_val = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_val = {{16{load_half[15]}}, load_half};
      3'b100:  load_val = {24'h000000, load_byte};
      3'b101:  load_val = {16'h0000, load_half};
      default: load_val = rdata;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= StIdle;
    else         state <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state;
    case (state)
      StIdle:  if (access && !i_dmem_ack) state_next = StWait;
      StWait:  if (i_dmem_ack || !access) state_next = StIdle;
      default: state_next = StIdle;
    endcase
  end

  // FSM outputs: request is held in both states until ack
  always_comb begin
    o_dmem_req   = access;
    o_dmem_we    = access && em_mem_write;
    o_dmem_wstrb = (access && em_mem_write) ? store_strb : 4'b0000;
    o_dmem_wdata = store_data;
    o_dmem_addr  = em_alu[DMEM_ADDR_BITS+1:2];
    o_stall      = access && !i_dmem_ack;
    o_misaligned = mis_op && !mis_seen;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      em_alu        <= '0;
      em_rt         <= '0;
      em_rd         <= '0;
      em_pc_to_reg  <= 1'b0;
      em_pc_return  <= '0;
      em_reg_write  <= 1'b0;
      em_mem_read   <= 1'b0;
      em_mem_write  <= 1'b0;
      em_mem_to_reg <= 1'b0;
      em_ls_op      <= 3'b000;
      acc_done      <= 1'b0;
      mis_seen      <= 1'b0;
      cap_rdata     <= '0;
    end else if (advance) begin
      em_alu        <= i_alu_result;
      em_rt         <= i_rt_data;
      em_rd         <= i_rd;
      em_pc_to_reg  <= i_pc_to_reg;
      em_pc_return  <= i_pc_return;
      em_reg_write  <= i_RegWrite;
      em_mem_read   <= i_MemRead;
      em_mem_write  <= i_MemWrite;
      em_mem_to_reg <= i_MemtoReg;
      em_ls_op      <= i_ls_filter_op;
      acc_done      <= 1'b0;
      mis_seen      <= 1'b0;
    end else begin
      if (access && i_dmem_ack) begin
        acc_done  <= 1'b1;
        cap_rdata <= i_dmem_rdata;
      end
      if (mis_op && !i_enable) mis_seen <= 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
    end else if (i_enable) begin
      if (o_stall || mis_op) begin
        wb_data      <= '0;
        wb_rd        <= '0;
        wb_reg_write <= 1'b0;
      end else begin
        wb_data      <= em_mem_to_reg ? PROC_BITS'(load_val) : ex_data;
        wb_rd        <= em_rd;
        wb_reg_write <= em_reg_write;
      end
    end
  end

  assign o_ex_mem_data     = ex_data;
  assign o_ex_mem_rd       = em_rd;
  assign o_ex_mem_RegWrite = em_reg_write;
  assign o_mem_wb_data     = wb_data;
  assign o_mem_wb_rd       = wb_rd;
  assign o_mem_wb_RegWrite = wb_reg_write;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table for single accesses, hand sequences for wait states,
// frozen-pipeline completion and reset mid-access; writebacks checked against a scoreboard queue.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [31:0] alu, rt, pc_ret;
  logic [4:0]  rd;
  logic        pc_to_reg, reg_write, mem_read, mem_write, mem_to_reg;
  logic [2:0]  op;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        stall, mis;
  logic [31:0] ex_mem_data, mem_wb_data;
  logic [4:0]  ex_mem_rd, mem_wb_rd;
  logic        ex_mem_rw, mem_wb_rw;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en),
    .i_alu_result(alu), .i_rt_data(rt), .i_rd(rd),
    .i_pc_to_reg(pc_to_reg), .i_pc_return(pc_ret),
    .i_RegWrite(reg_write), .i_MemRead(mem_read), .i_MemWrite(mem_write),
    .i_MemtoReg(mem_to_reg), .i_ls_filter_op(op),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_wdata(dmem_wdata), .o_dmem_wstrb(dmem_wstrb),
    .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata),
    .o_stall(stall), .o_misaligned(mis),
    .o_ex_mem_data(ex_mem_data), .o_ex_mem_rd(ex_mem_rd), .o_ex_mem_RegWrite(ex_mem_rw),
    .o_mem_wb_data(mem_wb_data), .o_mem_wb_rd(mem_wb_rd), .o_mem_wb_RegWrite(mem_wb_rw)
  );

  typedef struct {
    string       name;
    logic [31:0] alu, rt, pc_ret, rdata;
    logic [4:0]  rd;
    logic        pc_to_reg, reg_write, mem_read, mem_write, mem_to_reg;
    logic [2:0]  op;
    logic        exp_req, exp_we, exp_mis;
    logic [9:0]  exp_addr;
    logic [31:0] exp_wdata, exp_exdata, exp_wb;
    logic [3:0]  exp_wstrb;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } wb_t;

  localparam int NV = 14;
  vec_t vecs[NV];
  wb_t  sb_q[$];
  wb_t  mon_e;
  logic mon_upd;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_ex(input vec_t v);
    alu = v.alu; rt = v.rt; pc_ret = v.pc_ret; rd = v.rd;
    pc_to_reg = v.pc_to_reg; reg_write = v.reg_write; mem_read = v.mem_read;
    mem_write = v.mem_write; mem_to_reg = v.mem_to_reg; op = v.op;
  endtask

  task automatic drive_nop();
    alu = '0; rt = '0; pc_ret = '0; rd = '0; pc_to_reg = 0; reg_write = 0;
    mem_read = 0; mem_write = 0; mem_to_reg = 0; op = 3'b000;
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [4:0] r, input logic load);
    vec_t v;
    v.name = "seq"; v.alu = a; v.rt = '0; v.pc_ret = '0; v.rdata = '0; v.rd = r;
    v.pc_to_reg = 0; v.reg_write = 1; v.mem_read = load; v.mem_write = 0;
    v.mem_to_reg = load; v.op = 3'b010; v.exp_req = 0; v.exp_we = 0; v.exp_mis = 0;
    v.exp_addr = '0; v.exp_wdata = '0; v.exp_exdata = '0; v.exp_wb = '0; v.exp_wstrb = '0;
    return v;
  endfunction

  // Scoreboard: every MEM/WB update that writes a register must match the oldest expectation
  always @(posedge clk) begin
    mon_upd = en && !rst;
    #1;
    if (mon_upd && mem_wb_rw) begin
      if (sb_q.size() == 0) begin
        check("wb_unexpected_write", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("wb_data", mem_wb_data, mon_e.data);
        check("wb_rd", 32'(mem_wb_rd), 32'(mon_e.rd));
      end
    end
  end

  initial begin
    vec_t v, lw, add;
    int stall_cnt, req_cnt, done_cnt, bubble_cnt, addr_bad;
    logic was_stall;

    //          name      alu            rt             pc_ret  rdata          rd  p2r rw mr mw m2r op      req we mis addr     wdata          exdata         wb             wstrb
    vecs[0]  = '{"alu",   32'h1234_5678, 32'h0,         32'h0,  32'h0,         3,  0, 1, 0, 0, 0, 3'b010, 0, 0, 0, 10'h19E, 32'h0,         32'h1234_5678, 32'h1234_5678, 4'b0000};
    vecs[1]  = '{"lb",    32'h6,         32'h0,         32'h0,  32'h1280_3456, 5,  0, 1, 1, 0, 1, 3'b000, 1, 0, 0, 10'h001, 32'h0,         32'h6,         32'hFFFF_FF80, 4'b0000};
    vecs[2]  = '{"lbu",   32'h6,         32'h0,         32'h0,  32'h1280_3456, 6,  0, 1, 1, 0, 1, 3'b100, 1, 0, 0, 10'h001, 32'h0,         32'h6,         32'h0000_0080, 4'b0000};
    vecs[3]  = '{"lh",    32'h102,       32'h0,         32'h0,  32'h8001_7FFF, 7,  0, 1, 1, 0, 1, 3'b001, 1, 0, 0, 10'h040, 32'h0,         32'h102,       32'hFFFF_8001, 4'b0000};
    vecs[4]  = '{"lhu",   32'h100,       32'h0,         32'h0,  32'h8001_F00D, 8,  0, 1, 1, 0, 1, 3'b101, 1, 0, 0, 10'h040, 32'h0,         32'h100,       32'h0000_F00D, 4'b0000};
    vecs[5]  = '{"lw",    32'h3FC,       32'h0,         32'h0,  32'hDEAD_BEEF, 9,  0, 1, 1, 0, 1, 3'b010, 1, 0, 0, 10'h0FF, 32'h0,         32'h3FC,       32'hDEAD_BEEF, 4'b0000};
    vecs[6]  = '{"lb3",   32'h3,         32'h0,         32'h0,  32'h7F00_0000, 10, 0, 1, 1, 0, 1, 3'b000, 1, 0, 0, 10'h000, 32'h0,         32'h3,         32'h0000_007F, 4'b0000};
    vecs[7]  = '{"sh",    32'hA,         32'h0000_BEEF, 32'h0,  32'h0,         0,  0, 0, 0, 1, 0, 3'b001, 1, 1, 0, 10'h002, 32'hBEEF_BEEF, 32'hA,         32'h0,         4'b1100};
    vecs[8]  = '{"sb",    32'h7,         32'h1234_56A5, 32'h0,  32'h0,         0,  0, 0, 0, 1, 0, 3'b000, 1, 1, 0, 10'h001, 32'hA5A5_A5A5, 32'h7,         32'h0,         4'b1000};
    vecs[9]  = '{"sw",    32'h10,        32'hCAFE_F00D, 32'h0,  32'h0,         0,  0, 0, 0, 1, 0, 3'b010, 1, 1, 0, 10'h004, 32'hCAFE_F00D, 32'h10,        32'h0,         4'b1111};
    vecs[10] = '{"lw_mis",32'h2,         32'h0,         32'h0,  32'h1111_1111, 11, 0, 1, 1, 0, 1, 3'b010, 0, 0, 1, 10'h000, 32'h0,         32'h2,         32'h0,         4'b0000};
    vecs[11] = '{"lh_mis",32'h5,         32'h0,         32'h0,  32'h2222_2222, 12, 0, 1, 1, 0, 1, 3'b001, 0, 0, 1, 10'h001, 32'h0,         32'h5,         32'h0,         4'b0000};
    vecs[12] = '{"sw_mis",32'h1,         32'h5555_5555, 32'h0,  32'h0,         0,  0, 0, 0, 1, 0, 3'b010, 0, 0, 1, 10'h000, 32'h0,         32'h1,         32'h0,         4'b0000};
    vecs[13] = '{"jal",   32'h999,       32'h0,         32'h40, 32'h0,         31, 1, 1, 0, 0, 0, 3'b010, 0, 0, 0, 10'h266, 32'h0,         32'h40,        32'h40,        4'b0000};

    rst = 1; en = 1; dmem_ack = 0; dmem_rdata = '0;
    drive_nop();
    repeat (2) @(posedge clk);
    #2;
    check("rst_req", 32'(dmem_req), 0);
    check("rst_we", 32'(dmem_we), 0);
    check("rst_wstrb", 32'(dmem_wstrb), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_mis", 32'(mis), 0);
    check("rst_ex_mem_data", ex_mem_data, 0);
    check("rst_mem_wb_rw", 32'(mem_wb_rw), 0);
    check("rst_mem_wb_data", mem_wb_data, 0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      dmem_ack = 0;
      drive_ex(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      drive_nop();
      dmem_ack = 1;
      dmem_rdata = vecs[i].rdata;
      #1;
      check($sformatf("%s_req", vecs[i].name), 32'(dmem_req), 32'(vecs[i].exp_req));
      check($sformatf("%s_we", vecs[i].name), 32'(dmem_we), 32'(vecs[i].exp_we));
      check($sformatf("%s_wstrb", vecs[i].name), 32'(dmem_wstrb), 32'(vecs[i].exp_wstrb));
      check($sformatf("%s_mis", vecs[i].name), 32'(mis), 32'(vecs[i].exp_mis));
      check($sformatf("%s_stall", vecs[i].name), 32'(stall), 0);
      check($sformatf("%s_addr", vecs[i].name), 32'(dmem_addr), 32'(vecs[i].exp_addr));
      if (vecs[i].exp_we)
        check($sformatf("%s_wdata", vecs[i].name), dmem_wdata, vecs[i].exp_wdata);
      check($sformatf("%s_ex_data", vecs[i].name), ex_mem_data, vecs[i].exp_exdata);
      check($sformatf("%s_ex_rd", vecs[i].name), 32'(ex_mem_rd), 32'(vecs[i].rd));
      check($sformatf("%s_ex_rw", vecs[i].name), 32'(ex_mem_rw), 32'(vecs[i].reg_write));
      if (vecs[i].reg_write && !vecs[i].exp_mis) sb_q.push_back('{vecs[i].exp_wb, vecs[i].rd});
      @(posedge clk);
      #2;
      check($sformatf("%s_mis_pulse_end", vecs[i].name), 32'(mis), 0);
    end

    // Load with three wait states, followed by a dependent-free ALU op held during the stall
    @(negedge clk);
    dmem_ack = 0;
    lw = mk(32'h20, 5'd9, 1'b1);
    add = mk(32'h55, 5'd10, 1'b0);
    drive_ex(lw);
    sb_q.push_back('{32'h0BAD_F00D, 5'd9});
    @(posedge clk);
    @(negedge clk);
    drive_ex(add);
    sb_q.push_back('{32'h55, 5'd10});
    stall_cnt = 0; req_cnt = 0; done_cnt = 0; bubble_cnt = 0; addr_bad = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) drive_nop();
      dmem_ack = (c == 3);
      dmem_rdata = 32'h0BAD_F00D;
      #1;
      was_stall = stall;
      if (stall) stall_cnt++;
      if (dmem_req) req_cnt++;
      if (dmem_req && dmem_ack) done_cnt++;
      if (dmem_req && dmem_addr != 10'h008) addr_bad++;
      @(posedge clk);
      #2;
      if (was_stall && !mem_wb_rw) bubble_cnt++;
      @(negedge clk);
    end
    dmem_ack = 0;
    check("wait_stall_cycles", stall_cnt, 3);
    check("wait_req_cycles", req_cnt, 4);
    check("wait_completions", done_cnt, 1);
    check("wait_bubbles", bubble_cnt, 3);
    check("wait_addr_stable", addr_bad, 0);

    // Access completes while the pipeline is frozen; must advance later without a second request
    v = mk(32'h40, 5'd12, 1'b1);
    drive_ex(v);
    sb_q.push_back('{32'h1357_9BDF, 5'd12});
    @(posedge clk);
    @(negedge clk);
    drive_nop();
    en = 0;
    #1;
    check("frz_req_wait", 32'(dmem_req), 1);
    check("frz_stall_wait", 32'(stall), 1);
    @(posedge clk);
    @(negedge clk);
    dmem_ack = 1;
    dmem_rdata = 32'h1357_9BDF;
    #1;
    check("frz_req_ack", 32'(dmem_req), 1);
    check("frz_stall_ack", 32'(stall), 0);
    @(posedge clk);
    @(negedge clk);
    dmem_ack = 0;
    dmem_rdata = 32'hFFFF_FFFF;
    #1;
    check("frz_no_rereq", 32'(dmem_req), 0);
    check("frz_no_stall", 32'(stall), 0);
    @(posedge clk);
    #2;
    check("frz_wb_held", 32'(mem_wb_rw), 0);
    @(negedge clk);
    en = 1;
    #1;
    check("frz_no_rereq_en", 32'(dmem_req), 0);
    @(posedge clk);
    #2;
    check("frz_wb_rw", 32'(mem_wb_rw), 1);

    // Reset while a request is pending; a late ack must be ignored
    @(negedge clk);
    v = mk(32'h80, 5'd4, 1'b1);
    drive_ex(v);
    @(posedge clk);
    @(negedge clk);
    drive_nop();
    #1;
    check("rstm_req_pending", 32'(dmem_req), 1);
    rst = 1;
    @(posedge clk);
    #2;
    check("rstm_req", 32'(dmem_req), 0);
    check("rstm_stall", 32'(stall), 0);
    check("rstm_ex_rw", 32'(ex_mem_rw), 0);
    check("rstm_wb_rw", 32'(mem_wb_rw), 0);
    @(negedge clk);
    rst = 0;
    dmem_ack = 1;
    dmem_rdata = 32'hFFFF_FFFF;
    #1;
    check("rstm_late_ack_req", 32'(dmem_req), 0);
    check("rstm_late_ack_stall", 32'(stall), 0);
    @(posedge clk);
    #2;
    check("rstm_late_ack_wb", 32'(mem_wb_rw), 0);
    @(negedge clk);
    dmem_ack = 0;

    repeat (2) @(posedge clk);
    #2;
    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
